// File: rtl/chk_pkg.sv
// Shared types and helpers for the chain response checker.
package chk_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        TIMEOUT = 2'd2
    } chk_state_t;

    // Widest counter sat_inc can handle. Narrower counters are zero-extended into it.
    localparam int unsigned SAT_MAX_W = 32;

    // Saturating increment of a counter that is `width` bits wide.
    // The result sticks at all-ones and never wraps.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] all_ones;
        all_ones = (width >= SAT_MAX_W) ? '1
                                        : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
        return (value >= all_ones) ? all_ones : (value + SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops clear on reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop catches the async input; the second gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/chain_response_checker.sv
// Receiver for prsim co-simulation. It pairs each stimulus edge with the matching
// response edge from the far end of the netlist and measures the latency between them.
// It also counts good edges, timeouts, glitches and overruns.
module chain_response_checker
    import chk_pkg::*;
#(
    parameter bit          INVERT  = 1'b1,
    parameter int unsigned MAX_LAT = 16,
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stim,
    input  logic             resp,
    input  logic             clear,
    output logic             busy,
    output logic             err_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] glitch_count,
    output logic [CNT_W-1:0] overrun_count,
    output logic [LAT_W-1:0] last_latency
);

    chk_state_t state_q, state_d;

    logic             stim_s, resp_s;
    logic             stim_prev, resp_prev;
    logic             stim_edge, resp_edge, resp_match;
    logic             exp_q, exp_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             pending;
    logic             inc_edge, inc_timeout, inc_glitch, inc_overrun;
    logic             load_lat;
    logic             err_d;

    sync2 u_sync_stim (
        .clk   (clk),
        .reset (reset),
        .d     (stim),
        .q     (stim_s)
    );

    sync2 u_sync_resp (
        .clk   (clk),
        .reset (reset),
        .d     (resp),
        .q     (resp_s)
    );

    // An edge is any change of the synchronized value since the previous cycle.
    always_comb begin
        stim_edge  = stim_s ^ stim_prev;
        resp_edge  = resp_s ^ resp_prev;
        resp_match = (resp_s == exp_q);
    end

    // Next-state logic. The response is resolved against the old expectation first,
    // then a stimulus edge (if present) re-arms the FSM on top of that result.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        exp_d       = exp_q;
        pending     = 1'b0;
        inc_edge    = 1'b0;
        inc_timeout = 1'b0;
        inc_glitch  = 1'b0;
        inc_overrun = 1'b0;
        load_lat    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (resp_edge) begin
                    inc_glitch = 1'b1;
                end
            end
            WAIT: begin
                if (resp_edge && resp_match) begin
                    inc_edge = 1'b1;
                    load_lat = 1'b1;
                    state_d  = IDLE;
                end else begin
                    inc_glitch = resp_edge;
                    pending    = 1'b1;
                end
            end
            TIMEOUT: begin
                // A matching edge here is a late arrival: it closes the lost response silently.
                if (resp_edge) begin
                    if (resp_match) begin
                        state_d = IDLE;
                    end else begin
                        inc_glitch = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stim_edge) begin
            inc_overrun = pending;
            state_d     = WAIT;
            lat_d       = LAT_W'(1);
            exp_d       = stim_s ^ INVERT;
        end else if (pending) begin
            if (lat_q >= LAT_W'(MAX_LAT)) begin
                inc_timeout = 1'b1;
                state_d     = TIMEOUT;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end

        err_d = inc_timeout | inc_glitch | inc_overrun;
    end

    // FSM state register. busy mirrors the WAIT state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == WAIT);
        end
    end

    // Edge history, expected response, latency counter and error strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim_prev <= 1'b0;
            resp_prev <= 1'b0;
            exp_q     <= 1'b0;
            lat_q     <= '0;
            err_pulse <= 1'b0;
        end else begin
            stim_prev <= stim_s;
            resp_prev <= resp_s;
            exp_q     <= exp_d;
            lat_q     <= lat_d;
            err_pulse <= err_d;
        end
    end

    // Saturating event counters and the last good latency. clear overrides any increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            edge_count    <= '0;
            timeout_count <= '0;
            glitch_count  <= '0;
            overrun_count <= '0;
            last_latency  <= '0;
        end else begin
            if (inc_edge) begin
                edge_count <= CNT_W'(sat_inc(SAT_MAX_W'(edge_count), CNT_W));
            end
            if (inc_timeout) begin
                timeout_count <= CNT_W'(sat_inc(SAT_MAX_W'(timeout_count), CNT_W));
            end
            if (inc_glitch) begin
                glitch_count <= CNT_W'(sat_inc(SAT_MAX_W'(glitch_count), CNT_W));
            end
            if (inc_overrun) begin
                overrun_count <= CNT_W'(sat_inc(SAT_MAX_W'(overrun_count), CNT_W));
            end
            if (load_lat) begin
                last_latency <= lat_q;
            end
        end
    end

endmodule

// File: tb/tb_chain_response_checker.sv
// Directed bench for chain_response_checker. A delay line models the prsim inverter chain.
`timescale 1ns/1ps
module tb_chain_response_checker;
    import chk_pkg::*;

    localparam int unsigned LAT_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT4_W = 4;

    logic clk = 1'b0;
    logic reset, clear;
    logic stim, resp, resp_man, use_chain;
    logic stim4, resp4;
    int unsigned chain_dly;
    logic [31:0] pipe  = '0;
    logic [31:0] pipe4 = '0;

    logic              busy, err_pulse;
    logic [CNT_W-1:0]  edge_count, timeout_count, glitch_count, overrun_count;
    logic [LAT_W-1:0]  last_latency;
    logic              busy4, err_pulse4;
    logic [CNT4_W-1:0] edge_count4, timeout_count4, glitch_count4, overrun_count4;
    logic [LAT_W-1:0]  last_latency4;

    int checks = 0;
    int errors = 0;
    int unsigned sb_q[$];
    logic [CNT_W-1:0] prev_edge;

    always #1 clk = ~clk;

    // Inverter chain model: the response is the inverted stimulus delayed by chain_dly cycles.
    always @(posedge clk) begin
        pipe  <= {pipe[30:0], stim};
        pipe4 <= {pipe4[30:0], stim4};
    end
    assign resp  = use_chain ? ~pipe[chain_dly-1] : resp_man;
    assign resp4 = ~pipe4[4];

    chain_response_checker #(.INVERT(1'b1), .MAX_LAT(16), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stim(stim), .resp(resp), .clear(clear),
        .busy(busy), .err_pulse(err_pulse), .edge_count(edge_count),
        .timeout_count(timeout_count), .glitch_count(glitch_count),
        .overrun_count(overrun_count), .last_latency(last_latency)
    );

    chain_response_checker #(.INVERT(1'b1), .MAX_LAT(16), .LAT_W(LAT_W), .CNT_W(CNT4_W)) dut4 (
        .clk(clk), .reset(reset), .stim(stim4), .resp(resp4), .clear(clear),
        .busy(busy4), .err_pulse(err_pulse4), .edge_count(edge_count4),
        .timeout_count(timeout_count4), .glitch_count(glitch_count4),
        .overrun_count(overrun_count4), .last_latency(last_latency4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset, let start-up edges and chain contents flush, then clear the counters.
    task automatic settle();
        reset = 1'b1;
        clear = 1'b0;
        step(2);
        reset = 1'b0;
        step(20);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
    endtask

    // Scoreboard: each good-edge completion pops the expected latency.
    always @(negedge clk) begin
        if (edge_count == prev_edge + CNT_W'(1)) begin
            if (sb_q.size() != 0) begin
                check("sb_latency", 32'(last_latency), sb_q.pop_front());
            end else begin
                check("sb_unexpected_edge", 32'(last_latency), 32'hFFFF_FFFF);
            end
        end
        prev_edge = edge_count;
    end

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        stim      = 1'b0;
        stim4     = 1'b0;
        resp_man  = 1'b0;
        use_chain = 1'b1;
        chain_dly = 5;

        // Reset state
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_pulse), 0);
        check("rst_edge", 32'(edge_count), 0);
        check("rst_timeout", 32'(timeout_count), 0);
        check("rst_glitch", 32'(glitch_count), 0);
        check("rst_overrun", 32'(overrun_count), 0);
        check("rst_lat", 32'(last_latency), 0);

        // Ten good edges through a 5-cycle chain
        settle();
        check("t1_clean_glitch", 32'(glitch_count), 0);
        for (int i = 0; i < 10; i++) begin
            stim = ~stim;
            sb_q.push_back(5);
            step(20);
        end
        check("t1_edge", 32'(edge_count), 10);
        check("t1_timeout", 32'(timeout_count), 0);
        check("t1_glitch", 32'(glitch_count), 0);
        check("t1_overrun", 32'(overrun_count), 0);
        check("t1_lat", 32'(last_latency), 5);
        check("t1_sb_drained", sb_q.size(), 0);

        // Response stuck at 0: timeout after MAX_LAT cycles
        use_chain = 1'b0;
        resp_man  = 1'b0;
        stim      = 1'b0;
        settle();
        stim = 1'b1;
        step(18);
        check("t2_no_early_timeout", 32'(timeout_count), 0);
        check("t2_busy_waiting", 32'(busy), 1);
        step(1);
        check("t2_timeout", 32'(timeout_count), 1);
        check("t2_err_pulse", 32'(err_pulse), 1);
        check("t2_busy_off", 32'(busy), 0);
        check("t2_state", 32'(dut.state_q), 32'(TIMEOUT));
        step(1);
        check("t2_err_single", 32'(err_pulse), 0);
        resp_man = 1'b1;
        step(6);
        check("t2_mismatch_glitch", 32'(glitch_count), 1);
        check("t2_mismatch_state", 32'(dut.state_q), 32'(TIMEOUT));
        resp_man = 1'b0;
        step(6);
        check("t2_late_state", 32'(dut.state_q), 32'(IDLE));
        check("t2_late_edge", 32'(edge_count), 0);
        check("t2_late_glitch", 32'(glitch_count), 1);
        check("t2_late_timeout", 32'(timeout_count), 1);

        // Lone response edge while idle
        stim     = 1'b0;
        resp_man = 1'b0;
        settle();
        begin
            int busy_seen;
            int err_cycles;
            busy_seen  = 0;
            err_cycles = 0;
            resp_man   = 1'b1;
            for (int i = 0; i < 8; i++) begin
                step(1);
                busy_seen  += int'(busy);
                err_cycles += int'(err_pulse);
            end
            check("t3_glitch", 32'(glitch_count), 1);
            check("t3_edge", 32'(edge_count), 0);
            check("t3_busy_never", 32'(busy_seen), 0);
            check("t3_err_cycles", 32'(err_cycles), 1);
        end

        // Overrun: two stimulus edges 3 cycles apart, 10-cycle chain
        use_chain = 1'b1;
        chain_dly = 10;
        stim      = 1'b0;
        settle();
        stim = 1'b1;
        step(3);
        stim = 1'b0;
        sb_q.push_back(10);
        step(30);
        check("t4_overrun", 32'(overrun_count), 1);
        check("t4_glitch", 32'(glitch_count), 1);
        check("t4_edge", 32'(edge_count), 1);
        check("t4_lat", 32'(last_latency), 10);
        check("t4_timeout", 32'(timeout_count), 0);
        check("t4_sb_drained", sb_q.size(), 0);

        // Narrow counters saturate, then clear wins over a same-cycle increment
        settle();
        for (int i = 0; i < 20; i++) begin
            stim4 = ~stim4;
            step(12);
        end
        check("t5_saturate", 32'(edge_count4), 15);
        check("t5_glitch", 32'(glitch_count4), 0);
        check("t5_timeout", 32'(timeout_count4), 0);
        check("t5_overrun", 32'(overrun_count4), 0);
        stim4 = ~stim4;
        step(7);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t5_clear_wins", 32'(edge_count4), 0);
        check("t5_clear_lat", 32'(last_latency4), 0);
        step(4);
        stim4 = ~stim4;
        step(12);
        check("t5_after_clear", 32'(edge_count4), 1);
        check("t5_after_lat", 32'(last_latency4), 5);
        check("t5_busy", 32'(busy4), 0);
        check("t5_err", 32'(err_pulse4), 0);

        // Reset while a response is pending
        use_chain = 1'b0;
        resp_man  = 1'b1;
        stim      = 1'b0;
        settle();
        stim = 1'b1;
        step(5);
        check("t6_busy_before", 32'(busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_err", 32'(err_pulse), 0);
        check("t6_rst_edge", 32'(edge_count), 0);
        check("t6_rst_glitch", 32'(glitch_count), 0);
        check("t6_rst_lat", 32'(last_latency), 0);
        step(8);
        check("t6_glitch", 32'(glitch_count), 1);
        check("t6_edge", 32'(edge_count), 0);
        check("t6_overrun", 32'(overrun_count), 0);
        check("t6_rearmed", 32'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
